// File: rtl/color_ctrl.sv
// Keyboard-driven colour controller: make codes step per-channel values,
// break sequences (F0 xx) are filtered, E0 prefixes are ignored.
module color_ctrl #(
  parameter int unsigned         CH      = 3,
  parameter int unsigned         W       = 3,
  parameter logic [CH*8-1:0]     KEYS    = {8'h2D, 8'h34, 8'h32},
  parameter logic [7:0]          CLR_KEY = 8'h66
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flag,
  input  logic [7:0]      scancode,
  input  logic [1:0]      mode,
  output logic [CH*W-1:0] rgb,
  output logic [CH-1:0]   dir,
  output logic            upd
);

  localparam logic [7:0]   BrkCode = 8'hF0;
  localparam logic [7:0]   ExtCode = 8'hE0;
  localparam logic [W-1:0] Max     = {W{1'b1}};
  localparam logic [W-1:0] One     = W'(1);
  localparam logic [W-1:0] MaxM1   = Max - One;

  typedef enum logic {StMake, StBrk} state_e;

  state_e          state_q, state_d;
  logic [CH*W-1:0] rgb_q, rgb_d;
  logic [CH-1:0]   dir_q, dir_d;
  logic            upd_q, upd_d;

  // Returns {new_dir, new_value}; bounce folds back at the rails so a channel
  // entering bounce at 0 or MAX never wraps.
  function automatic logic [W:0] step_chan(input logic [W-1:0] v, input logic d,
                                           input logic [1:0] m);
    logic [W-1:0] nv;
    logic         nd;
    nv = v;
    nd = d;
    unique case (m)
      2'b00: begin
        if (d) begin
          if (v == Max) begin
            nv = MaxM1;
            nd = 1'b0;
          end else begin
            nv = v + One;
            nd = (v != MaxM1);
          end
        end else begin
          if (v == '0) begin
            nv = One;
            nd = 1'b1;
          end else begin
            nv = v - One;
            nd = (v == One);
          end
        end
      end
      2'b01: nv = v + One;
      2'b10: if (v != Max) nv = v + One;
      2'b11: if (v != '0) nv = v - One;
    endcase
    return {nd, nv};
  endfunction

  always_comb begin
    state_d = state_q;
    rgb_d   = rgb_q;
    dir_d   = dir_q;
    if (flag && scancode != ExtCode) begin
      unique case (state_q)
        StMake: begin
          if (scancode == BrkCode) begin
            state_d = StBrk;
          end else if (scancode == CLR_KEY) begin
            rgb_d = '0;
            dir_d = '1;
          end else begin
            for (int unsigned i = 0; i < CH; i++) begin
              if (scancode == KEYS[8*i +: 8]) begin
                {dir_d[i], rgb_d[W*i +: W]} = step_chan(rgb_q[W*i +: W], dir_q[i], mode);
              end
            end
          end
        end
        StBrk: state_d = StMake;
      endcase
    end
    upd_d = (rgb_d != rgb_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StMake;
      rgb_q   <= '0;
      dir_q   <= '1;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rgb_q   <= rgb_d;
      dir_q   <= dir_d;
      upd_q   <= upd_d;
    end
  end

  assign rgb = rgb_q;
  assign dir = dir_q;
  assign upd = upd_q;

endmodule

// File: tb/tb_color_ctrl.sv
// Drives a default and a 4x4-bit color_ctrl from shared stimulus and compares
// both against an integer reference model, plus directed scenario checks.
module tb_color_ctrl;

  logic        clk = 1'b0;
  logic        reset, flag;
  logic [7:0]  scancode;
  logic [1:0]  mode;
  logic [8:0]  rgb0;
  logic [2:0]  dir0;
  logic        upd0;
  logic [15:0] rgb1;
  logic [3:0]  dir1;
  logic        upd1;

  always #5 clk = ~clk;

  color_ctrl u_dut0 (
    .clk      (clk),
    .reset    (reset),
    .flag     (flag),
    .scancode (scancode),
    .mode     (mode),
    .rgb      (rgb0),
    .dir      (dir0),
    .upd      (upd0)
  );

  color_ctrl #(
    .CH   (4),
    .W    (4),
    .KEYS ({8'h1C, 8'h2D, 8'h34, 8'h32})
  ) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .flag     (flag),
    .scancode (scancode),
    .mode     (mode),
    .rgb      (rgb1),
    .dir      (dir1),
    .upd      (upd1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one row per DUT instance.
  int mval[2][8];
  bit mdir[2][8];
  bit mbrk[2];
  bit mupd[2];
  int mch[2] = '{3, 4};
  int mw[2]  = '{3, 4};
  int mkey[2][8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rgb(input int k);
    logic [31:0] r = '0;
    for (int c = 0; c < mch[k]; c++) r = r | (32'(mval[k][c]) << (mw[k] * c));
    return r;
  endfunction

  function automatic logic [31:0] m_dir(input int k);
    logic [31:0] r = '0;
    for (int c = 0; c < mch[k]; c++) r[c] = mdir[k][c];
    return r;
  endfunction

  task automatic model_apply(input int k, input bit rst_n, input bit f, input int sc,
                             input int md);
    int mx;
    bit chg;
    mx  = (1 << mw[k]) - 1;
    chg = 1'b0;
    if (!rst_n) begin
      for (int c = 0; c < 8; c++) begin
        mval[k][c] = 0;
        mdir[k][c] = 1'b1;
      end
      mbrk[k] = 1'b0;
      mupd[k] = 1'b0;
      return;
    end
    mupd[k] = 1'b0;
    if (!f || sc == 'hE0) return;
    if (mbrk[k]) begin
      mbrk[k] = 1'b0;
      return;
    end
    if (sc == 'hF0) begin
      mbrk[k] = 1'b1;
      return;
    end
    if (sc == 'h66) begin
      for (int c = 0; c < mch[k]; c++) begin
        if (mval[k][c] != 0) chg = 1'b1;
        mval[k][c] = 0;
        mdir[k][c] = 1'b1;
      end
      mupd[k] = chg;
      return;
    end
    for (int c = 0; c < mch[k]; c++) begin
      if (mkey[k][c] == sc) begin
        int v, nv;
        bit nd;
        v  = mval[k][c];
        nv = v;
        nd = mdir[k][c];
        case (md)
          0: begin
            if (nd) begin
              if (v >= mx) begin nv = mx - 1; nd = 1'b0; end
              else begin nv = v + 1; nd = (nv != mx); end
            end else begin
              if (v <= 0) begin nv = 1; nd = 1'b1; end
              else begin nv = v - 1; nd = (nv == 0); end
            end
          end
          1: nv = (v + 1) % (mx + 1);
          2: nv = (v < mx) ? v + 1 : v;
          default: nv = (v > 0) ? v - 1 : v;
        endcase
        if (nv != v) chg = 1'b1;
        mval[k][c] = nv;
        mdir[k][c] = nd;
      end
    end
    mupd[k] = chg;
  endtask

  task automatic tick(input bit rst_n, input bit f, input logic [7:0] sc, input logic [1:0] md);
    reset    = rst_n;
    flag     = f;
    scancode = sc;
    mode     = md;
    @(posedge clk);
    model_apply(0, rst_n, f, int'(sc), int'(md));
    model_apply(1, rst_n, f, int'(sc), int'(md));
    #1;
    check_eq("rgb0", 32'(rgb0), m_rgb(0));
    check_eq("dir0", 32'(dir0), m_dir(0));
    check_eq("upd0", 32'(upd0), 32'(mupd[0]));
    check_eq("rgb1", 32'(rgb1), m_rgb(1));
    check_eq("dir1", 32'(dir1), m_dir(1));
    check_eq("upd1", 32'(upd1), 32'(mupd[1]));
  endtask

  task automatic press(input logic [7:0] sc, input logic [1:0] md);
    tick(1'b1, 1'b1, sc, md);
  endtask

  initial begin
    int exp_red[8] = '{1, 2, 3, 4, 5, 6, 7, 6};
    int upd_cnt;
    int peak;
    logic [7:0] pool[7] = '{8'h2D, 8'h34, 8'h32, 8'h1C, 8'h66, 8'hF0, 8'hE0};
    logic [7:0] sc;

    mkey[0][0] = 'h32; mkey[0][1] = 'h34; mkey[0][2] = 'h2D;
    mkey[1][0] = 'h32; mkey[1][1] = 'h34; mkey[1][2] = 'h2D; mkey[1][3] = 'h1C;
    for (int c = 3; c < 8; c++) mkey[0][c] = -1;
    for (int c = 4; c < 8; c++) mkey[1][c] = -1;

    reset = 1'b0; flag = 1'b0; scancode = '0; mode = '0;
    tick(1'b0, 1'b1, 8'hF0, 2'b00);
    tick(1'b0, 1'b0, 8'h00, 2'b00);
    check_eq("rst_rgb", 32'(rgb0), 32'h0);
    check_eq("rst_dir", 32'(dir0), 32'h7);
    tick(1'b1, 1'b0, 8'h2D, 2'b00);

    // Bounce sequence on red
    for (int i = 0; i < 8; i++) begin
      press(8'h2D, 2'b00);
      check_eq("bounce_red", 32'(rgb0[8:6]), 32'(exp_red[i]));
      if (i == 6) check_eq("bounce_dir_at7", 32'(dir0[2]), 32'h0);
    end

    // Break filter on green
    upd_cnt = 0;
    press(8'hF0, 2'b00); upd_cnt += int'(upd0);
    press(8'h34, 2'b00); upd_cnt += int'(upd0);
    check_eq("brk_green", 32'(rgb0[5:3]), 32'h0);
    press(8'h34, 2'b00); upd_cnt += int'(upd0);
    check_eq("brk_green2", 32'(rgb0[5:3]), 32'h1);
    check_eq("brk_upd_cnt", 32'(upd_cnt), 32'h1);

    // Extended prefix on blue
    press(8'hE0, 2'b00); press(8'hF0, 2'b00); press(8'hE0, 2'b00); press(8'h32, 2'b00);
    check_eq("ext_blue", 32'(rgb0[2:0]), 32'h0);
    press(8'h32, 2'b00);
    check_eq("ext_blue2", 32'(rgb0[2:0]), 32'h1);

    // Wrap and saturation on blue
    for (int i = 0; i < 6; i++) press(8'h32, 2'b01);
    check_eq("wrap_pre", 32'(rgb0[2:0]), 32'h7);
    press(8'h32, 2'b01);
    check_eq("wrap_blue", 32'(rgb0[2:0]), 32'h0);
    for (int i = 0; i < 7; i++) press(8'h32, 2'b01);
    press(8'h32, 2'b10);
    check_eq("sat_blue", 32'(rgb0[2:0]), 32'h7);
    check_eq("sat_upd", 32'(upd0), 32'h0);
    press(8'h32, 2'b00);
    check_eq("bounce_from_max", 32'(rgb0[2:0]), 32'h6);

    // Clear, idle clear, reset discarding a pending break
    press(8'h66, 2'b00);
    check_eq("clr_rgb", 32'(rgb0), 32'h0);
    check_eq("clr_dir", 32'(dir0), 32'h7);
    check_eq("clr_upd", 32'(upd0), 32'h1);
    press(8'h66, 2'b00);
    check_eq("clr_idle_upd", 32'(upd0), 32'h0);
    press(8'hF0, 2'b00);
    tick(1'b0, 1'b1, 8'h2D, 2'b00);
    press(8'h2D, 2'b00);
    check_eq("rst_brk_red", 32'(rgb0[8:6]), 32'h1);

    // Wide instance: key 1C drives the top nibble, bounce peaks at 15
    peak = 0;
    for (int i = 0; i < 16; i++) begin
      press(8'h1C, 2'b00);
      if (int'(rgb1[15:12]) > peak) peak = int'(rgb1[15:12]);
    end
    check_eq("wide_peak", 32'(peak), 32'd15);
    check_eq("wide_after", 32'(rgb1[15:12]), 32'd14);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      int idx;
      idx = int'($urandom_range(0, 7));
      if (idx == 7) sc = 8'($urandom);
      else sc = pool[idx];
      tick(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 7), sc,
           2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
